// File: rtl/fetch_pc_unit.sv
// fetch_pc_unit
// -------------
// Fetch stage owning the program counter. The current fetch PC is presented
// to the branch buffer, whose predicted next PC is taken as the next PC unless
// a branch resolved in EX was mispredicted, in which case fetch is redirected
// to the correct PC and the younger instruction in IF/ID is invalidated.
// The fetched instruction and its prediction metadata are latched into the
// IF/ID register. Two saturating counters track resolved branches and
// mispredictions.
//
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   F_BP_target_pc/F_BP_taken predicted next PC and taken bit for F_pc
//   F_instr                  instruction memory data for F_pc (same cycle)
//   F_stall                  decode hazard stall: hold PC and IF/ID
//   MEM_stall                memory stall: freeze entire front end
//   EX_*                     resolution info of the instruction in EX
//   F_pc                     current fetch PC (registered)
//   D_*                      IF/ID register contents (registered)
//   X_flush                  combinational kill of ID/EX on a mispredict
//   branch_cnt, mispred_cnt  saturating performance counters (registered)

module fetch_pc_unit #(
    parameter int                 PC_BITS    = 12,
    parameter int                 INSTR_BITS = 32,
    parameter logic [PC_BITS-1:0] RESET_PC   = '0,
    parameter int                 CNT_BITS   = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [PC_BITS-1:0]    F_BP_target_pc,
    input  logic                  F_BP_taken,
    input  logic [INSTR_BITS-1:0] F_instr,
    input  logic                  F_stall,
    input  logic                  MEM_stall,
    input  logic                  EX_brn,
    input  logic [PC_BITS-1:0]    EX_pc,
    input  logic [PC_BITS-1:0]    EX_alu_out,
    input  logic                  EX_true_taken,
    input  logic                  EX_pred_taken,
    input  logic [PC_BITS-1:0]    EX_pred_target,
    output logic [PC_BITS-1:0]    F_pc,
    output logic                  D_valid,
    output logic [PC_BITS-1:0]    D_pc,
    output logic [INSTR_BITS-1:0] D_instr,
    output logic                  D_pred_taken,
    output logic [PC_BITS-1:0]    D_pred_target,
    output logic                  X_flush,
    output logic [CNT_BITS-1:0]   branch_cnt,
    output logic [CNT_BITS-1:0]   mispred_cnt
);

    // Saturating increment: sticks at all-ones instead of wrapping.
    function automatic logic [CNT_BITS-1:0] sat_inc(input logic [CNT_BITS-1:0] v);
        logic [CNT_BITS-1:0] r;
        if (v == {CNT_BITS{1'b1}}) begin
            r = v;
        end else begin
            r = v + CNT_BITS'(1);
        end
        return r;
    endfunction

    logic [PC_BITS-1:0]    pc_r;
    logic                  d_valid_r;
    logic [PC_BITS-1:0]    d_pc_r;
    logic [INSTR_BITS-1:0] d_instr_r;
    logic                  d_pred_taken_r;
    logic [PC_BITS-1:0]    d_pred_target_r;
    logic [CNT_BITS-1:0]   branch_cnt_r;
    logic [CNT_BITS-1:0]   mispred_cnt_r;

    logic                  mis_s;
    logic [PC_BITS-1:0]    correct_pc_s;
    logic                  br_evt_s;

    // Mispredict detection and redirect target from the EX resolution.
    // A taken branch with the right direction but wrong target also counts.
    // The not-taken PC wraps naturally at PC_BITS.
    always_comb begin
        mis_s        = 1'b0;
        correct_pc_s = '0;
        br_evt_s     = EX_brn & ~MEM_stall;
        if (br_evt_s) begin
            mis_s = (EX_true_taken != EX_pred_taken) |
                    (EX_true_taken & (EX_pred_target != EX_alu_out));
        end else begin
            mis_s = 1'b0;
        end
        if (EX_true_taken) begin
            correct_pc_s = EX_alu_out;
        end else begin
            correct_pc_s = EX_pc + PC_BITS'(1);
        end
    end

    // PC and IF/ID register: reset > MEM_stall > mispredict > F_stall > fetch.
    always_ff @(posedge clk) begin
        if (rst) begin
            pc_r            <= RESET_PC;
            d_valid_r       <= 1'b0;
            d_pc_r          <= '0;
            d_instr_r       <= '0;
            d_pred_taken_r  <= 1'b0;
            d_pred_target_r <= '0;
        end else if (!MEM_stall) begin
            if (mis_s) begin
                pc_r      <= correct_pc_s;
                d_valid_r <= 1'b0;
            end else if (!F_stall) begin
                pc_r            <= F_BP_target_pc;
                d_valid_r       <= 1'b1;
                d_pc_r          <= pc_r;
                d_instr_r       <= F_instr;
                d_pred_taken_r  <= F_BP_taken;
                d_pred_target_r <= F_BP_target_pc;
            end
        end
    end

    // Performance counters, advanced only for branches actually resolving.
    always_ff @(posedge clk) begin
        if (rst) begin
            branch_cnt_r  <= '0;
            mispred_cnt_r <= '0;
        end else if (br_evt_s) begin
            branch_cnt_r <= sat_inc(branch_cnt_r);
            if (mis_s) begin
                mispred_cnt_r <= sat_inc(mispred_cnt_r);
            end
        end
    end

    assign F_pc          = pc_r;
    assign D_valid       = d_valid_r;
    assign D_pc          = d_pc_r;
    assign D_instr       = d_instr_r;
    assign D_pred_taken  = d_pred_taken_r;
    assign D_pred_target = d_pred_target_r;
    assign X_flush       = mis_s;
    assign branch_cnt    = branch_cnt_r;
    assign mispred_cnt   = mispred_cnt_r;

endmodule

// File: tb/tb_fetch_pc_unit.sv
// Self-checking bench for fetch_pc_unit: directed scenarios followed by
// randomized traffic, all compared against a cycle-level reference model.
module tb_fetch_pc_unit;
    localparam int PCB = 12;
    localparam int IB  = 32;
    localparam int CB  = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic           rst;
    logic [PCB-1:0] F_BP_target_pc;
    logic           F_BP_taken;
    logic [IB-1:0]  F_instr;
    logic           F_stall, MEM_stall, EX_brn;
    logic [PCB-1:0] EX_pc, EX_alu_out, EX_pred_target;
    logic           EX_true_taken, EX_pred_taken;
    logic [PCB-1:0] F_pc, D_pc, D_pred_target;
    logic           D_valid, D_pred_taken, X_flush;
    logic [IB-1:0]  D_instr;
    logic [CB-1:0]  branch_cnt, mispred_cnt;

    // Branch-buffer knobs driven by the bench
    logic           bp_hit;
    logic [PCB-1:0] bp_tgt;

    fetch_pc_unit #(.PC_BITS(PCB), .INSTR_BITS(IB), .RESET_PC(12'h000), .CNT_BITS(CB)) dut (
        .clk(clk), .rst(rst),
        .F_BP_target_pc(F_BP_target_pc), .F_BP_taken(F_BP_taken), .F_instr(F_instr),
        .F_stall(F_stall), .MEM_stall(MEM_stall), .EX_brn(EX_brn), .EX_pc(EX_pc),
        .EX_alu_out(EX_alu_out), .EX_true_taken(EX_true_taken), .EX_pred_taken(EX_pred_taken),
        .EX_pred_target(EX_pred_target), .F_pc(F_pc), .D_valid(D_valid), .D_pc(D_pc),
        .D_instr(D_instr), .D_pred_taken(D_pred_taken), .D_pred_target(D_pred_target),
        .X_flush(X_flush), .branch_cnt(branch_cnt), .mispred_cnt(mispred_cnt)
    );

    // Instruction memory content: a fixed hash of the address
    function automatic logic [IB-1:0] instr_of(input logic [PCB-1:0] pc);
        return 32'hC0DE0000 ^ ({20'd0, pc} * 32'h9E3779B1);
    endfunction

    // Environment models: instruction memory and a branch buffer that
    // returns either a bench-chosen target or the sequential PC.
    assign F_instr        = instr_of(F_pc);
    assign F_BP_taken     = bp_hit;
    assign F_BP_target_pc = bp_hit ? bp_tgt : F_pc + 12'd1;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: observed %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Reference model state
    int m_pc, m_dpc, m_dtgt, m_br, m_mp;
    logic m_dv, m_dpt;
    logic [IB-1:0] m_dinstr;

    // One clock cycle with inputs already applied (called just after a negedge)
    task automatic cycle();
        bit exp_mis;
        int corr, nxt;
        exp_mis = EX_brn && !MEM_stall &&
                  ((EX_true_taken != EX_pred_taken) ||
                   (EX_true_taken && (EX_pred_target != EX_alu_out)));
        #1;
        check("x_flush", {63'd0, X_flush}, {63'd0, exp_mis});
        corr = EX_true_taken ? int'(EX_alu_out) : (int'(EX_pc) + 1) % 4096;
        nxt  = bp_hit ? int'(bp_tgt) : (m_pc + 1) % 4096;
        if (rst) begin
            m_pc = 0; m_dv = 0; m_dpc = 0; m_dinstr = '0; m_dpt = 0; m_dtgt = 0;
            m_br = 0; m_mp = 0;
        end else if (!MEM_stall) begin
            if (EX_brn) begin
                if (m_br < 15) m_br++;
                if (exp_mis && m_mp < 15) m_mp++;
            end
            if (exp_mis) begin
                m_pc = corr; m_dv = 0;
            end else if (!F_stall) begin
                m_dpc = m_pc; m_dinstr = instr_of(m_pc[PCB-1:0]);
                m_dpt = bp_hit; m_dtgt = nxt; m_pc = nxt; m_dv = 1;
            end
        end
        @(posedge clk);
        #1;
        check("f_pc",     64'(F_pc),          64'(m_pc));
        check("d_valid",  64'(D_valid),       64'(m_dv));
        check("d_pc",     64'(D_pc),          64'(m_dpc));
        check("d_instr",  64'(D_instr),       64'(m_dinstr));
        check("d_ptaken", 64'(D_pred_taken),  64'(m_dpt));
        check("d_ptgt",   64'(D_pred_target), 64'(m_dtgt));
        check("br_cnt",   64'(branch_cnt),    64'(m_br));
        check("mp_cnt",   64'(mispred_cnt),   64'(m_mp));
        @(negedge clk);
    endtask

    task automatic set_ex(input bit brn, input logic [PCB-1:0] pc, input bit pt,
                          input logic [PCB-1:0] ptgt, input bit tt, input logic [PCB-1:0] alu);
        EX_brn = brn; EX_pc = pc; EX_pred_taken = pt; EX_pred_target = ptgt;
        EX_true_taken = tt; EX_alu_out = alu;
    endtask

    initial begin
        rst = 1'b1; F_stall = 1'b0; MEM_stall = 1'b0; bp_hit = 1'b0; bp_tgt = 12'h000;
        set_ex(1'b0, 12'h000, 1'b0, 12'h000, 1'b0, 12'h000);
        @(negedge clk);
        cycle(); cycle();
        check("rst_pc", 64'(F_pc), 64'h0);
        check("rst_dv", 64'(D_valid), 64'h0);

        // Sequential fetch
        rst = 1'b0;
        cycle(); cycle();
        check("seq_dpc", 64'(D_pc), 64'h1);
        check("seq_dinstr", 64'(D_instr), 64'(instr_of(12'h001)));
        cycle(); cycle();
        check("seq_pc4", 64'(F_pc), 64'h4);

        // Predicted-taken hit at PC 4
        bp_hit = 1'b1; bp_tgt = 12'h020;
        cycle();
        check("bp_pc", 64'(F_pc), 64'h20);
        check("bp_dpt", 64'(D_pred_taken), 64'h1);
        check("bp_dtgt", 64'(D_pred_target), 64'h20);
        bp_hit = 1'b0;

        // Direction mispredict
        set_ex(1'b1, 12'h010, 1'b0, 12'h000, 1'b1, 12'h040);
        cycle();
        check("mis_pc", 64'(F_pc), 64'h40);
        check("mis_dv", 64'(D_valid), 64'h0);
        check("mis_br", 64'(branch_cnt), 64'h1);
        check("mis_mp", 64'(mispred_cnt), 64'h1);
        // Target mispredict
        set_ex(1'b1, 12'h011, 1'b1, 12'h030, 1'b1, 12'h034);
        cycle();
        check("tgt_pc", 64'(F_pc), 64'h34);
        // Not-taken at top of PC space wraps
        set_ex(1'b1, 12'hFFF, 1'b1, 12'h100, 1'b0, 12'h100);
        cycle();
        check("wrap_pc", 64'(F_pc), 64'h0);
        set_ex(1'b0, 12'h000, 1'b1, 12'h123, 1'b0, 12'h456);
        cycle();   // first corrected instruction lands in IF/ID

        // F_stall with a taken hit present holds everything
        F_stall = 1'b1; bp_hit = 1'b1; bp_tgt = 12'h055;
        cycle(); cycle(); cycle();
        check("fst_pc", 64'(F_pc), 64'h1);
        // Mispredict during F_stall still redirects
        set_ex(1'b1, 12'h200, 1'b0, 12'h000, 1'b1, 12'h300);
        cycle();
        check("fst_mis", 64'(F_pc), 64'h300);
        // Same mispredict under MEM_stall: frozen until it drops
        MEM_stall = 1'b1; F_stall = 1'b0;
        set_ex(1'b1, 12'h201, 1'b0, 12'h000, 1'b1, 12'h3A0);
        cycle(); cycle();
        check("mst_pc", 64'(F_pc), 64'h300);
        MEM_stall = 1'b0;
        cycle();
        check("mst_rel", 64'(F_pc), 64'h3A0);
        bp_hit = 1'b0;

        // Counter saturation
        for (int i = 0; i < 20; i++) begin
            set_ex(1'b1, 12'(i), 1'b0, 12'h000, 1'b1, 12'h080);
            cycle();
        end
        check("sat_br", 64'(branch_cnt), 64'hF);
        check("sat_mp", 64'(mispred_cnt), 64'hF);
        // Reset in the middle of a redirect
        rst = 1'b1;
        cycle();
        check("mrst_pc", 64'(F_pc), 64'h0);
        check("mrst_dv", 64'(D_valid), 64'h0);
        check("mrst_br", 64'(branch_cnt), 64'h0);
        rst = 1'b0;
        set_ex(1'b0, 12'h000, 1'b0, 12'h000, 1'b0, 12'h000);
        cycle();

        // Randomized traffic
        for (int i = 0; i < 3000; i++) begin
            rst       = ($urandom_range(0, 99) < 2);
            MEM_stall = ($urandom_range(0, 99) < 15);
            F_stall   = ($urandom_range(0, 99) < 20);
            bp_hit    = ($urandom_range(0, 99) < 30);
            bp_tgt    = 12'($urandom);
            EX_brn    = ($urandom_range(0, 99) < 40);
            EX_pc     = ($urandom_range(0, 9) == 0) ? 12'hFFF : 12'($urandom);
            EX_true_taken  = 1'($urandom);
            EX_pred_taken  = ($urandom_range(0, 3) == 0) ? ~EX_true_taken : EX_true_taken;
            EX_alu_out     = 12'($urandom);
            EX_pred_target = ($urandom_range(0, 3) == 0) ? 12'($urandom) : EX_alu_out;
            cycle();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
